// File: rtl/wb_stage.sv
// wb_stage -- writeback stage feeding the register file write port.
//
// Accepts completed instructions from execute over a valid/ready handshake.
// ALU results are written one cycle after acceptance. Loads park the stage in
// WAIT_LOAD until the data memory answers. The answered word is then cut down
// to a byte or half and sign- or zero-extended before being written. The stage
// also reports an outstanding load destination for hazard detection. It counts
// retired instructions and flags load timeouts and unsupported load types.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT_LOAD cycles before a load is abandoned (0 = never)
//   RETIRE_W        width of the retired-instruction counter
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   ex_valid / ex_ready         instruction handshake from execute
//   ex_rd_en, ex_rd_addr        destination enable and register
//   ex_result                   ALU / link value (unused for loads)
//   ex_is_load, ex_funct3       load flag and load type
//   ex_addr_lo                  load address bits [1:0]
//   mem_rvalid / mem_rready     load data handshake
//   mem_rdata                   aligned 32-bit memory word
//   rf_write_en, rf_rd_addr,
//   rf_rd_data                  registered register-file write port
//   pend_valid, pend_rd_addr    outstanding load with a nonzero destination
//   retire_count                instructions retired since reset (wraps)
//   err_timeout, err_funct3     single-cycle error pulses
module wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned RETIRE_W       = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                ex_rd_en,
  input  logic [4:0]          ex_rd_addr,
  input  logic [31:0]         ex_result,
  input  logic                ex_is_load,
  input  logic [2:0]          ex_funct3,
  input  logic [1:0]          ex_addr_lo,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  input  logic [31:0]         mem_rdata,
  output logic                rf_write_en,
  output logic [4:0]          rf_rd_addr,
  output logic [31:0]         rf_rd_data,
  output logic                pend_valid,
  output logic [4:0]          pend_rd_addr,
  output logic [RETIRE_W-1:0] retire_count,
  output logic                err_timeout,
  output logic                err_funct3
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      state, state_n;
  logic        ld_rd_en;
  logic [4:0]  ld_rd_addr;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] tmo_cnt;

  logic        accept_load;
  logic        retire_n;
  logic        wr_en_n;
  logic [4:0]  wr_addr_n;
  logic [31:0] wr_data_n;
  logic        err_to_n;
  logic        err_f3_n;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic        ld_bad;

  assign ex_ready     = (state == IDLE);
  assign mem_rready   = (state == WAIT_LOAD);
  assign pend_valid   = (state == WAIT_LOAD) && ld_rd_en && (ld_rd_addr != 5'd0);
  assign pend_rd_addr = pend_valid ? ld_rd_addr : 5'd0;

  // Load data extraction. Halves use only addr_lo[1], and words ignore addr_lo;
  // misalignment has already been dealt with by execute.
  always_comb begin
    ld_byte  = mem_rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_half  = ld_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_value = 32'd0;
    ld_bad   = 1'b0;
    case (ld_funct3)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_value = mem_rdata;
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_bad   = 1'b1;
    endcase
  end

  // Next-state and next-write logic. A response arriving in the last allowed
  // cycle is still taken as a normal completion rather than a timeout.
  always_comb begin
    state_n     = state;
    accept_load = 1'b0;
    retire_n    = 1'b0;
    wr_en_n     = 1'b0;
    wr_addr_n   = 5'd0;
    wr_data_n   = 32'd0;
    err_to_n    = 1'b0;
    err_f3_n    = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (ex_is_load) begin
            accept_load = 1'b1;
            state_n     = WAIT_LOAD;
          end else begin
            retire_n = 1'b1;
            if (ex_rd_en && (ex_rd_addr != 5'd0)) begin
              wr_en_n   = 1'b1;
              wr_addr_n = ex_rd_addr;
              wr_data_n = ex_result;
            end
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          state_n  = IDLE;
          retire_n = 1'b1;
          err_f3_n = ld_bad;
          if (ld_rd_en && (ld_rd_addr != 5'd0)) begin
            wr_en_n   = 1'b1;
            wr_addr_n = ld_rd_addr;
            wr_data_n = ld_value;
          end
        end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
          state_n  = IDLE;
          err_to_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Load bookkeeping, timeout counter, and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_rd_en     <= 1'b0;
      ld_rd_addr   <= 5'd0;
      ld_funct3    <= 3'd0;
      ld_addr_lo   <= 2'd0;
      tmo_cnt      <= 32'd0;
      rf_write_en  <= 1'b0;
      rf_rd_addr   <= 5'd0;
      rf_rd_data   <= 32'd0;
      err_timeout  <= 1'b0;
      err_funct3   <= 1'b0;
      retire_count <= '0;
    end else begin
      if (accept_load) begin
        ld_rd_en   <= ex_rd_en;
        ld_rd_addr <= ex_rd_addr;
        ld_funct3  <= ex_funct3;
        ld_addr_lo <= ex_addr_lo;
        tmo_cnt    <= 32'd0;
      end else if ((state == WAIT_LOAD) && !mem_rvalid) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
      rf_write_en <= wr_en_n;
      rf_rd_addr  <= wr_addr_n;
      rf_rd_data  <= wr_data_n;
      err_timeout <= err_to_n;
      err_funct3  <= err_f3_n;
      if (retire_n) begin
        retire_count <= retire_count + RETIRE_W'(1);
      end
    end
  end

endmodule
